// File: rtl/alu_operand_sequencer_if.sv
// Operand-entry bus between the board I/O (master) and the ALU operand sequencer (slave).
// The master side drives the key and switches; the slave side returns the committed operation.
interface alu_operand_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             i_key_n;
    logic [WIDTH-1:0] i_sw;
    logic [1:0]       i_ctrl;
    logic [WIDTH-1:0] o_a;
    logic [WIDTH-1:0] o_b;
    logic [1:0]       o_ctrl;
    logic             o_valid;
    logic [1:0]       o_phase;

    modport master (
        output i_key_n, i_sw, i_ctrl,
        input  o_a, o_b, o_ctrl, o_valid, o_phase
    );

    modport slave (
        input  i_key_n, i_sw, i_ctrl,
        output o_a, o_b, o_ctrl, o_valid, o_phase
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Operand-entry stage for the 4-bit ALU board: one debounced pushbutton steps the user
// through entering A, then B and the control code, and the result is shown until the next press.
module alu_operand_sequencer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic                  i_clk,
    input logic                  i_reset,
    alu_operand_sequencer_if.slave bus
);
    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        SHOW    = 2'b10
    } phase_e;

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    phase_e           phase_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       ctrl_q;
    logic             valid_q;

    // NOTE: non-blocking assignments make sync2_q take the previous sync1_q, giving a true
    // two-flop chain; blocking here would collapse it into a single stage.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.i_key_n;
            sync2_q <= sync1_q;
        end
    end

    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        deb_d   = deb_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d   = sync2_q;
                // A flip away from the released level (1) is a press; the reverse is a release.
                press_d = deb_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Operand and phase registers feed the ALU and LEDs directly.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else if (press_q) begin
            case (phase_q)
                ENTER_A: begin
                    a_q     <= bus.i_sw;
                    valid_q <= 1'b0;
                    phase_q <= ENTER_B;
                end
                ENTER_B: begin
                    b_q     <= bus.i_sw;
                    ctrl_q  <= bus.i_ctrl;
                    valid_q <= 1'b1;
                    phase_q <= SHOW;
                end
                SHOW: begin
                    valid_q <= 1'b0;
                    phase_q <= ENTER_A;
                end
                default: begin
                    valid_q <= 1'b0;
                    phase_q <= ENTER_A;
                end
            endcase
        end
    end

    assign bus.o_a     = a_q;
    assign bus.o_b     = b_q;
    assign bus.o_ctrl  = ctrl_q;
    assign bus.o_valid = valid_q;
    assign bus.o_phase = phase_q;
endmodule
